// File: rtl/dm_trace_capture_buffer_pkg.sv
// Capture buffer types: controller states and level sizing.
// Level counts 0..DEPTH inclusive, hence the +1.
package dm_trace_capture_datatypes;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } cap_state_e;

  function automatic int unsigned lvl_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  localparam int unsigned FIFO_DEPTH_DEF = 8;

  typedef logic [$clog2(FIFO_DEPTH_DEF+1)-1:0] fifo_level_t;

endpackage

// File: rtl/gouram_datatypes.sv
// Gouram trace types shared with the trace repository.
// trace_format is the per-instruction memory trace entry.
package gouram_datatypes;

  localparam int TRACE_ADDR_W = 16;

  typedef struct packed {
    logic [TRACE_ADDR_W-1:0] mem_addr;
    logic [31:0]             instruction;
  } trace_format;

endpackage

// File: rtl/dm_trace_capture_buffer_if.sv
// Gouram-side input and repository-side capture bundle.
// slave is the capture buffer, master is its environment.
interface dm_trace_capture_buffer_if
  import gouram_datatypes::*;
#(
  parameter int FIFO_DEPTH    = 8,
  parameter int OVF_CNT_WIDTH = 16
);

  localparam int LW = $clog2(FIFO_DEPTH + 1);

  trace_format              gouram_trace_in;
  logic                     gouram_trace_valid;
  logic                     lock;
  logic                     flush;
  trace_format              trace_out;
  logic                     trace_ready;
  logic                     trace_capture_enable;
  logic                     empty;
  logic [LW-1:0]            level;
  logic                     overflow;
  logic [OVF_CNT_WIDTH-1:0] overflow_count;

  modport master (
    output gouram_trace_in, gouram_trace_valid,
    output lock, flush,
    input  trace_out, trace_ready, trace_capture_enable,
    input  empty, level, overflow, overflow_count
  );

  modport slave (
    input  gouram_trace_in, gouram_trace_valid,
    input  lock, flush,
    output trace_out, trace_ready, trace_capture_enable,
    output empty, level, overflow, overflow_count
  );

endinterface

// File: rtl/dm_trace_capture_buffer_fifo.sv
// Register-based FIFO; a push into a full FIFO is taken
// when a pop happens in the same cycle.
module dm_trace_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Next pointers and occupancy from this cycle's push/pop.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    level_d = level_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
    if (do_push && !do_pop) level_d = level_q + 1'b1;
    if (do_pop && !do_push) level_d = level_q - 1'b1;
  end

  // Pointer/level registers; clear drops all content.
  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end

  // Entry storage, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/dm_trace_capture_buffer.sv
// Window filter + FIFO between Gouram and the repository;
// drains one entry per cycle while the repository is unlocked.
module dm_trace_capture_buffer
  import gouram_datatypes::*;
  import dm_trace_capture_datatypes::*;
#(
  parameter int DATA_ADDR_WIDTH = 16,
  parameter int FIFO_DEPTH      = 8,
  parameter logic [DATA_ADDR_WIDTH-1:0] ADDR_LO = '0,
  parameter logic [DATA_ADDR_WIDTH-1:0] ADDR_HI = '1,
  parameter int OVF_CNT_WIDTH   = 16
) (
  input logic                     clk,
  input logic                     rst_n,
  dm_trace_capture_buffer_if.slave bus
);

  localparam int LW = lvl_w(FIFO_DEPTH);
  localparam int TW = $bits(trace_format);

  cap_state_e               state_q, state_d;
  trace_format              trace_out_q;
  logic                     trace_ready_q;
  logic                     overflow_q;
  logic [OVF_CNT_WIDTH-1:0] ovf_cnt_q;

  logic [DATA_ADDR_WIDTH-1:0] addr;
  logic [DATA_ADDR_WIDTH:0]   lo_diff, hi_diff;
  logic                       in_win;
  logic                       push_req, pop, drop;
  logic                       f_full, f_empty;
  logic [LW-1:0]              f_level;
  logic [TW-1:0]              f_head;

  // Borrow-out of the subtractions gives unsigned compares.
  assign addr    = DATA_ADDR_WIDTH'(bus.gouram_trace_in.mem_addr);
  assign lo_diff = {1'b0, addr} - {1'b0, ADDR_LO};
  assign hi_diff = {1'b0, ADDR_HI} - {1'b0, addr};
  assign in_win  = !lo_diff[DATA_ADDR_WIDTH]
                && !hi_diff[DATA_ADDR_WIDTH];

  assign push_req = bus.gouram_trace_valid && in_win
                 && !bus.flush;
  assign pop  = (state_q == RUN) && !bus.lock
             && !bus.flush && !f_empty;
  assign drop = push_req && f_full && !pop;

  dm_trace_fifo #(
    .WIDTH (TW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (bus.flush),
    .push_i  (push_req),
    .pop_i   (pop),
    .wdata_i (bus.gouram_trace_in),
    .rdata_o (f_head),
    .full_o  (f_full),
    .empty_o (f_empty),
    .level_o (f_level)
  );

  // Flush wins from any state, otherwise lock picks HOLD/RUN.
  always_comb begin
    state_d = state_q;
    if (bus.flush)     state_d = FLUSH;
    else if (bus.lock) state_d = HOLD;
    else               state_d = RUN;
  end

  // State, output strobe/data register and loss counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= RUN;
      trace_out_q   <= '0;
      trace_ready_q <= 1'b0;
      overflow_q    <= 1'b0;
      ovf_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      trace_ready_q <= pop;
      if (pop) trace_out_q <= f_head;
      if (drop) begin
        overflow_q <= 1'b1;
        if (!(&ovf_cnt_q)) ovf_cnt_q <= ovf_cnt_q + 1'b1;
      end
    end
  end

  assign bus.trace_out            = trace_out_q;
  assign bus.trace_ready          = trace_ready_q;
  assign bus.trace_capture_enable = trace_ready_q;
  assign bus.empty                = f_empty && !trace_ready_q;
  assign bus.level                = f_level;
  assign bus.overflow             = overflow_q;
  assign bus.overflow_count       = ovf_cnt_q;

endmodule

// File: tb/tb_dm_trace_capture_buffer.sv
// Directed bench: dut0 uses the full address window,
// dut1 the 0x1000..0x1FFF window; both see the same stimulus.
module tb_dm_trace_capture_buffer;
  import gouram_datatypes::*;

  logic clk;
  logic rst_n;
  int   vec;
  int   errs;

  dm_trace_capture_buffer_if #(.FIFO_DEPTH(8), .OVF_CNT_WIDTH(16)) bus0 ();
  dm_trace_capture_buffer_if #(.FIFO_DEPTH(8), .OVF_CNT_WIDTH(16)) bus1 ();

  dm_trace_capture_buffer #(
    .DATA_ADDR_WIDTH (16),
    .FIFO_DEPTH      (8),
    .ADDR_LO         (16'h0000),
    .ADDR_HI         (16'hFFFF),
    .OVF_CNT_WIDTH   (16)
  ) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  dm_trace_capture_buffer #(
    .DATA_ADDR_WIDTH (16),
    .FIFO_DEPTH      (8),
    .ADDR_LO         (16'h1000),
    .ADDR_HI         (16'h1FFF),
    .OVF_CNT_WIDTH   (16)
  ) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] a,
                       input logic [31:0] ins);
    trace_format t;
    t.mem_addr    = a;
    t.instruction = ins;
    bus0.gouram_trace_valid = v;
    bus0.gouram_trace_in    = t;
    bus1.gouram_trace_valid = v;
    bus1.gouram_trace_in    = t;
  endtask

  task automatic set_lock(input logic l);
    bus0.lock = l;
    bus1.lock = l;
  endtask

  task automatic set_flush(input logic f);
    bus0.flush = f;
    bus1.flush = f;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 16'h0, 32'h0);
    set_lock(1'b0);
    set_flush(1'b0);
    tick();
    tick();
    vec++;
    if (bus0.trace_ready !== 1'b0 || bus0.trace_capture_enable !== 1'b0) begin
      errs++;
      $display("FAIL reset_ready: got %b/%b want 0/0",
               bus0.trace_ready, bus0.trace_capture_enable);
    end
    vec++;
    if (bus0.trace_out !== 48'h0) begin
      errs++;
      $display("FAIL reset_out: got %h want 0", bus0.trace_out);
    end
    vec++;
    if (bus0.empty !== 1'b1 || bus0.level !== 4'd0 || bus1.empty !== 1'b1) begin
      errs++;
      $display("FAIL reset_level: empty=%b level=%0d want 1/0",
               bus0.empty, bus0.level);
    end
    vec++;
    if (bus0.overflow !== 1'b0 || bus0.overflow_count !== 16'd0) begin
      errs++;
      $display("FAIL reset_ovf: got %b/%0d want 0/0",
               bus0.overflow, bus0.overflow_count);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    drive(1'b1, 16'h0040, 32'h00A12023);
    tick();
    drive(1'b0, 16'h0, 32'h0);
    vec++;
    if (bus0.trace_ready !== 1'b0 || bus0.level !== 4'd1) begin
      errs++;
      $display("FAIL single_edge1: ready=%b level=%0d want 0/1",
               bus0.trace_ready, bus0.level);
    end
    tick();
    vec++;
    if (bus0.trace_ready !== 1'b1 || bus0.trace_capture_enable !== 1'b1) begin
      errs++;
      $display("FAIL single_strobe: ready=%b cap=%b want 1/1",
               bus0.trace_ready, bus0.trace_capture_enable);
    end
    vec++;
    if (bus0.trace_out !== {16'h0040, 32'h00A12023}) begin
      errs++;
      $display("FAIL single_data: got %h want 004000a12023", bus0.trace_out);
    end
    vec++;
    if (bus0.level !== 4'd0 || bus0.empty !== 1'b0) begin
      errs++;
      $display("FAIL single_inflight: level=%0d empty=%b want 0/0",
               bus0.level, bus0.empty);
    end
    tick();
    vec++;
    if (bus0.trace_ready !== 1'b0 || bus0.empty !== 1'b1) begin
      errs++;
      $display("FAIL single_after: ready=%b empty=%b want 0/1",
               bus0.trace_ready, bus0.empty);
    end
    vec++;
    if (bus0.trace_out !== {16'h0040, 32'h00A12023}) begin
      errs++;
      $display("FAIL single_hold: got %h want 004000a12023", bus0.trace_out);
    end
  endtask

  task automatic test_window();
    logic [15:0] a [4];
    logic [15:0] ea [2];
    int got;
    a  = '{16'h0FFF, 16'h1000, 16'h1FFF, 16'h2000};
    ea = '{16'h1000, 16'h1FFF};
    got = 0;
    for (int c = 0; c < 10; c++) begin
      if (c < 4) drive(1'b1, a[c], {16'h5000, a[c]});
      else       drive(1'b0, 16'h0, 32'h0);
      tick();
      if (bus1.trace_ready === 1'b1) begin
        vec++;
        if (got >= 2) begin
          errs++;
          $display("FAIL window_extra: got %h want no entry",
                   bus1.trace_out.mem_addr);
        end else if (bus1.trace_out !== {ea[got], 16'h5000, ea[got]}) begin
          errs++;
          $display("FAIL window_data: got %h want %h%h%h",
                   bus1.trace_out, ea[got], 16'h5000, ea[got]);
        end
        got++;
      end
    end
    vec++;
    if (got != 2) begin
      errs++;
      $display("FAIL window_count: got %0d want 2", got);
    end
    vec++;
    if (bus1.overflow_count !== 16'd0 || bus1.overflow !== 1'b0) begin
      errs++;
      $display("FAIL window_ovf: got %0d want 0", bus1.overflow_count);
    end
  endtask

  task automatic test_overflow();
    int n;
    set_lock(1'b1);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 16'h0100 + 16'(i), 32'hC0DE0000 + 32'(i));
      tick();
    end
    drive(1'b0, 16'h0, 32'h0);
    vec++;
    if (bus0.level !== 4'd8 || bus0.trace_ready !== 1'b0) begin
      errs++;
      $display("FAIL ovf_level: level=%0d ready=%b want 8/0",
               bus0.level, bus0.trace_ready);
    end
    vec++;
    if (bus0.overflow !== 1'b1 || bus0.overflow_count !== 16'd2) begin
      errs++;
      $display("FAIL ovf_count: got %b/%0d want 1/2",
               bus0.overflow, bus0.overflow_count);
    end
    set_lock(1'b0);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus0.trace_ready !== 1'b1 && n < 6);
    vec++;
    if (bus0.trace_ready !== 1'b1) begin
      errs++;
      $display("FAIL ovf_timeout: ready=%b want 1 within 6 cycles",
               bus0.trace_ready);
    end
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      vec++;
      if (bus0.trace_ready !== 1'b1 ||
          bus0.trace_out !== {16'h0100 + 16'(k), 32'hC0DE0000 + 32'(k)}) begin
        errs++;
        $display("FAIL ovf_drain%0d: ready=%b out=%h want 1/%h%h", k,
                 bus0.trace_ready, bus0.trace_out,
                 16'h0100 + 16'(k), 32'hC0DE0000 + 32'(k));
      end
    end
    tick();
    vec++;
    if (bus0.trace_ready !== 1'b0 || bus0.empty !== 1'b1) begin
      errs++;
      $display("FAIL ovf_end: ready=%b empty=%b want 0/1",
               bus0.trace_ready, bus0.empty);
    end
  endtask

  task automatic test_back_to_back();
    set_lock(1'b1);
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 16'h0200 + 16'(k), 32'hA0000000 + 32'(k));
      tick();
    end
    drive(1'b0, 16'h0, 32'h0);
    set_lock(1'b0);
    tick();
    vec++;
    if (bus0.level !== 4'd8 || bus0.trace_ready !== 1'b0) begin
      errs++;
      $display("FAIL b2b_fill: level=%0d ready=%b want 8/0",
               bus0.level, bus0.trace_ready);
    end
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 16'h0208 + 16'(k), 32'hA0000008 + 32'(k));
      tick();
      vec++;
      if (bus0.level !== 4'd8 || bus0.trace_ready !== 1'b1 ||
          bus0.trace_out.instruction !== 32'hA0000000 + 32'(k)) begin
        errs++;
        $display("FAIL b2b_cycle%0d: level=%0d ready=%b ins=%h want 8/1/%h",
                 k, bus0.level, bus0.trace_ready,
                 bus0.trace_out.instruction, 32'hA0000000 + 32'(k));
      end
    end
    drive(1'b0, 16'h0, 32'h0);
    for (int k = 20; k < 28; k++) begin
      tick();
      vec++;
      if (bus0.trace_ready !== 1'b1 ||
          bus0.trace_out.instruction !== 32'hA0000000 + 32'(k)) begin
        errs++;
        $display("FAIL b2b_drain%0d: ready=%b ins=%h want 1/%h", k,
                 bus0.trace_ready, bus0.trace_out.instruction,
                 32'hA0000000 + 32'(k));
      end
    end
    tick();
    vec++;
    if (bus0.empty !== 1'b1 || bus0.overflow_count !== 16'd2) begin
      errs++;
      $display("FAIL b2b_end: empty=%b ovf_cnt=%0d want 1/2",
               bus0.empty, bus0.overflow_count);
    end
  endtask

  task automatic test_flush();
    int seen;
    int n;
    set_lock(1'b1);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 16'h0300 + 16'(k), 32'hF0000000 + 32'(k));
      tick();
    end
    vec++;
    if (bus0.level !== 4'd5) begin
      errs++;
      $display("FAIL flush_pre: level=%0d want 5", bus0.level);
    end
    drive(1'b1, 16'h0399, 32'hF0000099);
    set_flush(1'b1);
    tick();
    set_flush(1'b0);
    drive(1'b0, 16'h0, 32'h0);
    vec++;
    if (bus0.level !== 4'd0 || bus0.empty !== 1'b1 || bus0.trace_ready !== 1'b0) begin
      errs++;
      $display("FAIL flush_clear: level=%0d empty=%b ready=%b want 0/1/0",
               bus0.level, bus0.empty, bus0.trace_ready);
    end
    vec++;
    if (bus0.overflow_count !== 16'd2 || bus0.overflow !== 1'b1) begin
      errs++;
      $display("FAIL flush_ovf: got %b/%0d want 1/2",
               bus0.overflow, bus0.overflow_count);
    end
    set_lock(1'b0);
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus0.trace_ready === 1'b1) seen++;
    end
    vec++;
    if (seen != 0) begin
      errs++;
      $display("FAIL flush_quiet: got %0d strobes want 0", seen);
    end
    drive(1'b1, 16'h0355, 32'hF0000055);
    tick();
    drive(1'b0, 16'h0, 32'h0);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus0.trace_ready !== 1'b1 && n < 4);
    vec++;
    if (bus0.trace_ready !== 1'b1 || bus0.trace_out !== {16'h0355, 32'hF0000055}) begin
      errs++;
      $display("FAIL flush_resume: ready=%b out=%h want 1/0355f0000055",
               bus0.trace_ready, bus0.trace_out);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int seen;
    set_lock(1'b1);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 16'h0400 + 16'(k), 32'hB0000000 + 32'(k));
      tick();
    end
    drive(1'b0, 16'h0, 32'h0);
    set_lock(1'b0);
    tick();
    tick();
    tick();
    vec++;
    if (bus0.level !== 4'd3 || bus0.trace_ready !== 1'b1) begin
      errs++;
      $display("FAIL rstmid_pre: level=%0d ready=%b want 3/1",
               bus0.level, bus0.trace_ready);
    end
    rst_n = 1'b0;
    tick();
    vec++;
    if (bus0.trace_ready !== 1'b0 || bus0.trace_capture_enable !== 1'b0 ||
        bus0.trace_out !== 48'h0) begin
      errs++;
      $display("FAIL rstmid_out: ready=%b out=%h want 0/0",
               bus0.trace_ready, bus0.trace_out);
    end
    vec++;
    if (bus0.level !== 4'd0 || bus0.empty !== 1'b1 ||
        bus0.overflow !== 1'b0 || bus0.overflow_count !== 16'd0) begin
      errs++;
      $display("FAIL rstmid_state: level=%0d empty=%b ovf=%b cnt=%0d want 0/1/0/0",
               bus0.level, bus0.empty, bus0.overflow, bus0.overflow_count);
    end
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus0.trace_ready === 1'b1) seen++;
    end
    vec++;
    if (seen != 0 || bus0.level !== 4'd0) begin
      errs++;
      $display("FAIL rstmid_quiet: strobes=%0d level=%0d want 0/0",
               seen, bus0.level);
    end
  endtask

  initial begin
    vec  = 0;
    errs = 0;
    test_reset();
    test_single();
    test_window();
    test_overflow();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/dm_trace_capture_buffer.md
Name: dm_trace_capture_buffer

Overview:
- Sits directly upstream of the trace repository. Receives per-instruction memory trace entries from Gouram, filters them to a configured data-address window, and buffers them in a small FIFO.
- Drains the FIFO one entry per cycle into the repository's capture port (trace_in / trace_ready / trace_capture_enable), but only while the repository is unlocked.
- Absorbs bursts, reports loss, and tells the controller when it is empty so lock can be asserted safely.

Parameters:
- DATA_ADDR_WIDTH, 16, width of the trace mem_addr field.
- FIFO_DEPTH, 8, number of buffered entries; power of two, ≥2.
- ADDR_LO, 0, lowest mem_addr accepted (inclusive).
- ADDR_HI, 2**DATA_ADDR_WIDTH-1, highest mem_addr accepted (inclusive).
- OVF_CNT_WIDTH, 16, width of the drop counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- gouram_trace_in  in  trace_format  entry from Gouram (mem_addr, instruction).
- gouram_trace_valid  in  1  gouram_trace_in valid this cycle.
- lock  in  1  repository lock; high = no output.
- flush  in  1  one-cycle pulse; discard all buffered entries.
- trace_out  out  trace_format  entry to repository trace_in.
- trace_ready  out  1  one-cycle strobe; trace_out valid.
- trace_capture_enable  out  1  equals trace_ready.
- empty  out  1  FIFO empty and no strobe in flight.
- level  out  $clog2(FIFO_DEPTH+1)  current occupancy.
- overflow  out  1  sticky; an in-window entry was dropped.
- overflow_count  out  OVF_CNT_WIDTH  saturating count of dropped in-window entries.

Behaviour:
- Reset (rst_n low at posedge): pointers and level go to 0. trace_out=0, trace_ready=0, trace_capture_enable=0, empty=1, overflow=0, overflow_count=0, state=RUN. Reset mid-burst discards all content.
- Filter: an entry is in-window when ADDR_LO ≤ mem_addr ≤ ADDR_HI, compared unsigned. Out-of-window entries are ignored silently and never counted.
- Push: on gouram_trace_valid with an in-window entry, the entry is written at the next edge if level<FIFO_DEPTH, or if a pop occurs in the same cycle.
- Drop: when full with no simultaneous pop, the entry is dropped. overflow is set to 1. overflow_count increments and saturates at all-ones.
- Pop condition (combinational): state==RUN && !lock && level>0. On pop, trace_out is registered from the FIFO head and trace_ready/trace_capture_enable pulse high for exactly that next cycle.
- Output rate: sustained rate is 1 entry per cycle.
- Latency: an entry pushed into an empty FIFO at edge N is popped in cycle N and appears on trace_out with trace_ready at edge N+1 (2 edges from input valid). There is no bypass path.
- Level arithmetic: level +1 on push only, −1 on pop only, unchanged on both.
- Wrap: pointers are log2(FIFO_DEPTH) bits and wrap naturally.
- empty: = (level==0) && !trace_ready.
- FSM:
  - RUN: normal operation.
  - HOLD: entered when lock=1. No pops; pushes and drops continue. Returns to RUN the cycle after lock=0, and the first pop may occur in that same cycle.
  - FLUSH: entered on flush=1 from any state. At the next edge pointers and level go to 0, any trace_ready is cleared, and the state returns to RUN if lock=0, else HOLD.
  - A push coincident with flush is discarded and not counted. overflow and overflow_count are preserved across flush; only rst_n clears them.
- lock rising while trace_ready is high: that strobe still completes. The entry was popped before lock rose and is the controller's responsibility.
- trace_out holds its last value when trace_ready=0.

Decomposition:
- Package dm_trace_capture_datatypes: state enum (RUN, HOLD, FLUSH) and a fifo_level_t width helper. trace_format is reused from gouram_datatypes, not redefined.
- Sub-module dm_trace_fifo: synchronous register-based FIFO with width and depth parameters, push/pop/full/empty/level ports, and same-cycle push+pop when full. The top level holds the filter, FSM, output register and counters.

Test Plan:
- Reset then a single in-window entry (mem_addr=0x0040, instr=0x00A12023) with lock=0 -> trace_ready high exactly 1 cycle, 2 edges after valid; trace_out matches; level returns to 0; empty=1.
- ADDR_LO=0x1000, ADDR_HI=0x1FFF; send 0x0FFF, 0x1000, 0x1FFF, 0x2000 -> only 0x1000 and 0x1FFF are output, in order; overflow_count=0.
- lock=1, push 10 in-window entries with FIFO_DEPTH=8 -> level=8, overflow=1, overflow_count=2; deassert lock -> the first 8 entries emerge on 8 consecutive cycles in order.
- FIFO full with lock=0 and a push every cycle for 20 cycles -> no drops, output 1 per cycle, level stays constant.
- level=5, pulse flush together with a push -> level=0 and empty=1 next cycle; no trace_ready; overflow_count unchanged.
- level=3, assert rst_n=0 for 1 cycle mid-drain -> all outputs at reset values next edge; no further trace_ready.
